mdu_iter: RTL

- Iterative multiply/divide unit for the MIPS datapath.
- Sits beside the ALU in EX. Consumes the two register-file read operands (rs, rt) and holds the HI/LO result registers.
- HI/LO are read back through mfhi/mflo and written to the register file in WB.
- Radix-2, one bit per cycle, fixed latency. Asserts busy so the pipeline control stalls dependent mfhi/mflo/mult/div.

---
 rtl/mdu_iter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit with HI/LO result registers.
// One bit per cycle. The result is written 33 cycles after the launch edge.
// Ports:
//   clk, clrn       clock (rising edge) and asynchronous active-low reset
//   start, op       launch request, sampled only in IDLE
//                   (op: 00 mult, 01 multu, 10 div, 11 divu)
//   a, b            rs / rt operands, sampled on the launch edge only
//   hi_we, lo_we    mthi / mtlo write enables; wdata carries the write data
//   busy            operation in progress
//   done            one-cycle pulse after hi/lo are written by an operation
//   hi, lo          result registers: product high/low, or remainder/quotient
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   acc_q;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0] opb_q;     // multiplicand or divisor magnitude
    logic            is_div_q;
    logic            neg_q;      // negate product / quotient
    logic            rem_neg_q;  // negate remainder (dividend was negative)
    logic            busy_q;
    logic            done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // Operand sign handling at launch: only mult/div (op[0]=0) are signed.
    logic             is_signed_c;
    logic             sa_c;
    logic             sb_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;

    assign is_signed_c = ~op[0];
    assign sa_c        = is_signed_c & a[WIDTH-1];
    assign sb_c        = is_signed_c & b[WIDTH-1];
    assign mag_a_c     = sa_c ? -a : a;
    assign mag_b_c     = sb_c ? -b : b;

    // One shift-add multiply step: add multiplicand on LSB, then shift right with carry.
    logic [WIDTH:0]  mul_sum_c;
    logic [AW-1:0]   mul_next_c;

    assign mul_sum_c  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, opb_q};
    assign mul_next_c = acc_q[0] ? {mul_sum_c, acc_q[WIDTH-1:1]}
                                 : {1'b0, acc_q[AW-1:1]};

    // One restoring divide step on a 33-bit shifted partial remainder.
    logic [WIDTH:0]   div_shift_c;
    logic [WIDTH:0]   div_diff_c;
    logic             div_ge_c;
    logic [WIDTH-1:0] rem_next_c;
    logic [AW-1:0]    div_next_c;

    assign div_shift_c = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff_c  = div_shift_c - {1'b0, opb_q};
    assign div_ge_c    = (div_shift_c >= {1'b0, opb_q});
    assign rem_next_c  = div_ge_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
    assign div_next_c  = {rem_next_c, acc_q[WIDTH-2:0], div_ge_c};

    // Sign correction applied in SIGN.
    logic [AW-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quot_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    assign prod_fix_c = neg_q ? -acc_q : acc_q;
    assign quot_fix_c = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix_c  = rem_neg_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];

    // Control FSM, datapath registers and HI/LO.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_q     <= sa_c ^ sb_c;
                        rem_neg_q <= sa_c;
                        opb_q     <= mag_b_c;
                        acc_q     <= {WIDTH'(0), mag_a_c};
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                CALC: begin
                    acc_q <= is_div_q ? div_next_c : mul_next_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix_c;
                        lo_q <= quot_fix_c;
                    end else begin
                        hi_q <= prod_fix_c[AW-1:WIDTH];
                        lo_q <= prod_fix_c[WIDTH-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
